qcw_ramp_sequencer: RTL and testbench
=====================================

Name: qcw_ramp_sequencer

Overview:
Parametrised successor to the QCW phase-ramp controller. It holds a bus-loaded ramp table instead of a one-shot consumable FIFO. Each burst replays the table one entry per resonant cycle, either once or looped. It sits between the CPU bus (mem_* handshake) and the QCW bridge phase-shift generator, and drives qcw_phase_value and qcw_halt.

Parameters:
BASE_ADDR, 32'h0000_0000, byte base address of the register window (window size 0x20).
PHASE_W, 8, width of a phase entry and of qcw_phase_value.
DEPTH, 8192, number of table entries (power of two). AW = clog2(DEPTH).
CNT_W, 16, width of the cycle and loop counters.

Ports:
clk  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
mem_valid_i  in  1  bus request valid.
mem_ready_o  out  1  bus acknowledge, one-cycle pulse.
mem_addr_i  in  32  byte address.
mem_wdata_i  in  32  write data.
mem_wstrb_i  in  4  byte strobes; any bit set = write.
mem_rdata_o  out  32  read data, valid with mem_ready_o.
qcw_start  in  1  one-clk pulse: start a burst.
qcw_cycle_done  in  1  one-clk pulse per completed resonant cycle. The driver guarantees pulses are at least 3 clk apart.
qcw_halt  out  1  one-clk pulse: terminate the burst.
qcw_phase_value  out  PHASE_W  current phase command.

Behaviour:
- Reset: all outputs 0, state IDLE, all registers 0, LENGTH=0. Table contents are undefined. Reset mid-burst returns to IDLE immediately and does not pulse qcw_halt.
- Bus handshake:
  - A transaction is accepted on the first cycle valid is high with the window addressed.
  - mem_ready_o pulses 1 clk later, exactly once per valid assertion. It re-arms only after valid drops.
  - Unmapped offsets inside the window read 0 and ignore writes.
  - mem_rdata_o is 0 whenever ready is low.
- Register map (byte offsets):
  - 0x00 CTRL rw: [0] enable, [1] loop, [2] abort (write-1, self-clearing, reads 0).
  - 0x04 STATUS: [0] busy (ro), [1] done, [2] underrun, [3] wr_err. Bits [1..3] are sticky, write-1-to-clear.
  - 0x08 LENGTH rw, AW+1 bits. Writes above DEPTH clamp to DEPTH.
  - 0x0C TBL_ADDR rw, AW bits.
  - 0x10 TBL_DATA wo: writes table[TBL_ADDR]=wdata[PHASE_W-1:0], then TBL_ADDR increments, wrapping DEPTH-1 -> 0. Reads return 0.
  - 0x14 CYCLE_COUNT ro: qcw_cycle_done count since last start, saturating at all-ones.
  - 0x18 LOOP_COUNT ro: table wraps since last start, saturating.
  - 0x1C PHASE ro: qcw_phase_value, zero-extended.
- TBL_DATA or LENGTH write while busy: write dropped, wr_err set.
- FSM states: IDLE, PRIME, RUN.
  - IDLE -> PRIME on qcw_start when enable=1 and LENGTH>0. On entry: idx=0, counters cleared, table[0] read issued.
  - PRIME -> RUN after 1 clk. qcw_phase_value=table[0] is registered; table[1] is prefetched into a next-register.
  - RUN, on each qcw_cycle_done, the following update together:
    - CYCLE_COUNT increments.
    - If idx+1 < LENGTH: qcw_phase_value <= next-register exactly 1 clk later; idx increments; prefetch the following entry.
    - Else if loop=1: idx=0, output table[0] (prefetched), LOOP_COUNT increments.
    - Else: qcw_halt pulses 1 clk later, done is set, return to IDLE, qcw_phase_value holds its last entry.
  - LENGTH=1 with loop=0: halt on the first cycle_done. LENGTH=1 with loop=1: table[0] is output continuously.
- qcw_start when enable=1 and LENGTH=0: qcw_halt pulses 1 clk later, underrun is set, state stays IDLE.
- qcw_start when enable=0: ignored.
- qcw_start while PRIME/RUN: ignored; the burst continues.
- qcw_cycle_done in IDLE: qcw_halt pulses 1 clk later, underrun is set. This is the fail-safe against an unarmed bridge.
- Abort in PRIME/RUN: qcw_halt pulses 1 clk later, return to IDLE, done is not set. Abort wins over a simultaneous qcw_cycle_done.
- Start and cycle_done in the same clk in IDLE: start wins, and the cycle_done is not counted.
- Clearing enable mid-burst does not stop the burst; use abort.

Decomposition:
- Package qcw_pkg holds:
  - register offsets and ADDR_RANGE=0x20;
  - CTRL/STATUS bit indices;
  - FSM state enum (IDLE, PRIME, RUN).
- One sub-module, qcw_ramp_table:
  - simple dual-port synchronous RAM, DEPTH x PHASE_W, 1-clk read latency;
  - write port driven by the bus decode;
  - read port driven by the sequencer.

Test Plan:
1. Load table 10,20,30 via TBL_ADDR=0 and three TBL_DATA writes; LENGTH=3, CTRL=1; qcw_start, then 3 cycle_done pulses 10 clk apart -> phase 10 before the first done, 20 and 30 one clk after done 1 and 2; halt pulses 1 clk after done 3; STATUS=0x2; CYCLE_COUNT=3.
2. Same table with CTRL=3 (loop), 7 cycle_done pulses -> phase sequence 10,20,30,10,20,30,10,20; LOOP_COUNT=2; no halt; busy=1; then CTRL=0x4 -> halt 1 clk later and busy=0.
3. LENGTH=0, CTRL=1, qcw_start -> halt pulse 1 clk later; STATUS=0x4; write 0x4 to STATUS -> reads 0.
4. qcw_cycle_done in IDLE -> halt pulse and underrun set. qcw_start with enable=0 -> no state change.
5. During a burst, write TBL_DATA and LENGTH=5 -> both ignored, wr_err set, LENGTH still 3. Hold mem_valid_i for 4 clk -> exactly one ready pulse.
6. Assert reset mid-RUN -> next clk: phase=0, halt=0, busy=0, LENGTH=0. TBL_ADDR=DEPTH-1 plus two TBL_DATA writes -> TBL_ADDR=1.

Source files
------------

// File: rtl/qcw_pkg.sv
// Shared constants for the QCW ramp sequencer: register map, control/status
// bit positions and the sequencer state encoding.
package qcw_pkg;

  localparam logic [31:0] ADDR_RANGE = 32'h0000_0020;

  localparam logic [4:0] OFS_CTRL        = 5'h00;
  localparam logic [4:0] OFS_STATUS      = 5'h04;
  localparam logic [4:0] OFS_LENGTH      = 5'h08;
  localparam logic [4:0] OFS_TBL_ADDR    = 5'h0C;
  localparam logic [4:0] OFS_TBL_DATA    = 5'h10;
  localparam logic [4:0] OFS_CYCLE_COUNT = 5'h14;
  localparam logic [4:0] OFS_LOOP_COUNT  = 5'h18;
  localparam logic [4:0] OFS_PHASE       = 5'h1C;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_LOOP   = 1;
  localparam int CTRL_ABORT  = 2;

  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_UNDERRUN = 2;
  localparam int ST_WR_ERR   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/qcw_ramp_table.sv
// Ramp table storage: simple dual-port synchronous RAM, one write port from the
// bus decode and one read port with a registered (1-clk latency) output.
module qcw_ramp_table #(
  parameter int PHASE_W = 8,
  parameter int DEPTH   = 8192,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [PHASE_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [PHASE_W-1:0] rdata_o
);

  logic [PHASE_W-1:0] mem_q [DEPTH];
  logic [PHASE_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/qcw_ramp_sequencer.sv
// QCW phase-ramp sequencer: bus-loaded ramp table replayed one entry per
// resonant cycle, once or looped, with a CPU register window.
module qcw_ramp_sequencer
  import qcw_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          PHASE_W   = 8,
  parameter int          DEPTH     = 8192,
  parameter int          CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_valid_i,
  output logic               mem_ready_o,
  input  logic [31:0]        mem_addr_i,
  input  logic [31:0]        mem_wdata_i,
  input  logic [3:0]         mem_wstrb_i,
  output logic [31:0]        mem_rdata_o,
  input  logic               qcw_start,
  input  logic               qcw_cycle_done,
  output logic               qcw_halt,
  output logic [PHASE_W-1:0] qcw_phase_value
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);

  function automatic logic [AW:0] clamp_len(input logic [31:0] v);
    if (v > 32'(DEPTH)) begin
      return DEPTH_L;
    end
    return v[AW:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == '1) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  // Bus-side registers
  logic              served_q;
  logic              ready_q;
  logic [31:0]       rdata_q;
  logic              enable_q;
  logic              loop_q;
  logic [AW:0]       length_q;
  logic [AW-1:0]     tbl_addr_q;
  logic              wr_err_q;

  // Sequencer registers
  state_e             state_q;
  logic [AW-1:0]      idx_q;
  logic [PHASE_W-1:0] phase_q;
  logic               halt_q;
  logic [CNT_W-1:0]   cycle_cnt_q;
  logic [CNT_W-1:0]   loop_cnt_q;
  logic               done_q;
  logic               underrun_q;

  logic [31:0]        offset;
  logic [4:0]         ofs;
  logic               in_win;
  logic               accept;
  logic               wr_en;
  logic               wr_ctrl, wr_status, wr_length, wr_taddr, wr_tdata;
  logic               busy;
  logic               abort;
  logic               tbl_we;
  logic [2:0]         sts_clr;
  logic [31:0]        rdata_d;
  logic [AW:0]        nxt_idx;
  logic               more;
  logic [AW-1:0]      rd_addr;
  logic [PHASE_W-1:0] rd_data;

  // Address decode: offsets are relative to BASE_ADDR, modulo 2^32.
  assign offset    = mem_addr_i - BASE_ADDR;
  assign in_win    = (offset[31:5] == '0);
  assign ofs       = offset[4:0];
  assign accept    = mem_valid_i && in_win && !served_q;
  assign wr_en     = accept && (|mem_wstrb_i);
  assign wr_ctrl   = wr_en && (ofs == OFS_CTRL);
  assign wr_status = wr_en && (ofs == OFS_STATUS);
  assign wr_length = wr_en && (ofs == OFS_LENGTH);
  assign wr_taddr  = wr_en && (ofs == OFS_TBL_ADDR);
  assign wr_tdata  = wr_en && (ofs == OFS_TBL_DATA);
  assign busy      = (state_q != IDLE);
  assign abort     = wr_ctrl && mem_wdata_i[CTRL_ABORT];
  assign tbl_we    = wr_tdata && !busy;
  assign sts_clr   = wr_status ? mem_wdata_i[ST_WR_ERR:ST_DONE] : 3'b000;

  always_comb begin
    rdata_d = '0;
    case (ofs)
      OFS_CTRL:        rdata_d = 32'({loop_q, enable_q});
      OFS_STATUS:      rdata_d = 32'({wr_err_q, underrun_q, done_q, busy});
      OFS_LENGTH:      rdata_d = 32'(length_q);
      OFS_TBL_ADDR:    rdata_d = 32'(tbl_addr_q);
      OFS_CYCLE_COUNT: rdata_d = 32'(cycle_cnt_q);
      OFS_LOOP_COUNT:  rdata_d = 32'(loop_cnt_q);
      OFS_PHASE:       rdata_d = 32'(phase_q);
      default:         rdata_d = '0;
    endcase
  end

  // One acknowledge per valid assertion; re-armed only when valid drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      served_q   <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      enable_q   <= 1'b0;
      loop_q     <= 1'b0;
      length_q   <= '0;
      tbl_addr_q <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      served_q <= mem_valid_i && (served_q || accept);
      ready_q  <= accept;
      rdata_q  <= accept ? rdata_d : '0;
      if (wr_ctrl) begin
        enable_q <= mem_wdata_i[CTRL_ENABLE];
        loop_q   <= mem_wdata_i[CTRL_LOOP];
      end
      if (wr_length && !busy) begin
        length_q <= clamp_len(mem_wdata_i);
      end
      if (wr_taddr) begin
        tbl_addr_q <= mem_wdata_i[AW-1:0];
      end else if (tbl_we) begin
        tbl_addr_q <= tbl_addr_q + AW'(1);
      end
      if (sts_clr[2]) begin
        wr_err_q <= 1'b0;
      end
      if ((wr_length || wr_tdata) && busy) begin
        wr_err_q <= 1'b1;
      end
    end
  end

  // Prefetch address: the RAM output register always holds the entry that
  // follows idx (or entry 0 at the end of the table) once the burst is running.
  always_comb begin
    nxt_idx = {1'b0, idx_q} + (AW+1)'(1);
    more    = (nxt_idx < length_q);
    rd_addr = '0;
    if (state_q != IDLE && more) begin
      rd_addr = nxt_idx[AW-1:0];
    end
  end

  qcw_ramp_table #(
    .PHASE_W (PHASE_W),
    .DEPTH   (DEPTH),
    .AW      (AW)
  ) u_table (
    .clk     (clk),
    .we_i    (tbl_we),
    .waddr_i (tbl_addr_q),
    .wdata_i (mem_wdata_i[PHASE_W-1:0]),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      phase_q     <= '0;
      halt_q      <= 1'b0;
      cycle_cnt_q <= '0;
      loop_cnt_q  <= '0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      halt_q <= 1'b0;
      if (sts_clr[0]) done_q     <= 1'b0;
      if (sts_clr[1]) underrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Start wins over a coincident cycle_done, which is then not counted.
          if (qcw_start && enable_q && (length_q != '0)) begin
            state_q     <= PRIME;
            idx_q       <= '0;
            cycle_cnt_q <= '0;
            loop_cnt_q  <= '0;
          end else if ((qcw_start && enable_q) || qcw_cycle_done) begin
            halt_q     <= 1'b1;
            underrun_q <= 1'b1;
          end
        end
        PRIME: begin
          if (abort) begin
            halt_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            phase_q <= rd_data;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            halt_q  <= 1'b1;
            state_q <= IDLE;
          end else if (qcw_cycle_done) begin
            cycle_cnt_q <= sat_inc(cycle_cnt_q);
            if (more) begin
              phase_q <= rd_data;
              idx_q   <= nxt_idx[AW-1:0];
            end else if (loop_q) begin
              phase_q    <= rd_data;
              idx_q      <= '0;
              loop_cnt_q <= sat_inc(loop_cnt_q);
            end else begin
              halt_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_ready_o     = ready_q;
  assign mem_rdata_o     = rdata_q;
  assign qcw_halt        = halt_q;
  assign qcw_phase_value = phase_q;

endmodule

// File: tb/tb_qcw_ramp_sequencer.sv
// Self-checking bench for qcw_ramp_sequencer: directed scenarios plus
// randomized bursts compared against a table-replay reference model.
module tb_qcw_ramp_sequencer;

  localparam int          PHASE_W = 8;
  localparam int          DEPTH   = 16;
  localparam int          CNT_W   = 16;
  localparam logic [31:0] BASE    = 32'h4000_0100;

  localparam logic [4:0] R_CTRL   = 5'h00;
  localparam logic [4:0] R_STATUS = 5'h04;
  localparam logic [4:0] R_LENGTH = 5'h08;
  localparam logic [4:0] R_TADDR  = 5'h0C;
  localparam logic [4:0] R_TDATA  = 5'h10;
  localparam logic [4:0] R_CYCLE  = 5'h14;
  localparam logic [4:0] R_LOOP   = 5'h18;
  localparam logic [4:0] R_PHASE  = 5'h1C;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               mem_valid_i = 1'b0;
  logic               mem_ready_o;
  logic [31:0]        mem_addr_i = '0;
  logic [31:0]        mem_wdata_i = '0;
  logic [3:0]         mem_wstrb_i = '0;
  logic [31:0]        mem_rdata_o;
  logic               qcw_start = 1'b0;
  logic               qcw_cycle_done = 1'b0;
  logic               qcw_halt;
  logic [PHASE_W-1:0] qcw_phase_value;

  int          n_checks = 0;
  int          n_errors = 0;
  int          halt_cnt = 0;
  logic        halt_at_ack = 1'b0;
  logic [7:0]  tbl [DEPTH];

  qcw_ramp_sequencer #(
    .BASE_ADDR (BASE),
    .PHASE_W   (PHASE_W),
    .DEPTH     (DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_valid_i     (mem_valid_i),
    .mem_ready_o     (mem_ready_o),
    .mem_addr_i      (mem_addr_i),
    .mem_wdata_i     (mem_wdata_i),
    .mem_wstrb_i     (mem_wstrb_i),
    .mem_rdata_o     (mem_rdata_o),
    .qcw_start       (qcw_start),
    .qcw_cycle_done  (qcw_cycle_done),
    .qcw_halt        (qcw_halt),
    .qcw_phase_value (qcw_phase_value)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (qcw_halt) halt_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_xfer(input logic [4:0] ofs, input logic wr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
    int t;
    @(posedge clk); #1;
    mem_valid_i = 1'b1;
    mem_addr_i  = BASE + 32'(ofs);
    mem_wdata_i = wdata;
    mem_wstrb_i = wr ? 4'hF : 4'h0;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!mem_ready_o && t < 8);
    if (!mem_ready_o) check("bus_timeout", 32'(mem_ready_o), 32'd1);
    rdata       = mem_rdata_o;
    halt_at_ack = qcw_halt;
    mem_valid_i = 1'b0;
    mem_wstrb_i = 4'h0;
  endtask

  task automatic wr(input logic [4:0] ofs, input logic [31:0] d);
    logic [31:0] unused;
    bus_xfer(ofs, 1'b1, d, unused);
  endtask

  task automatic rd(input logic [4:0] ofs, output logic [31:0] d);
    bus_xfer(ofs, 1'b0, 32'h0, d);
  endtask

  task automatic pulse(input bit is_start);
    @(posedge clk); #1;
    if (is_start) qcw_start = 1'b1;
    else          qcw_cycle_done = 1'b1;
    @(posedge clk); #1;
    qcw_start      = 1'b0;
    qcw_cycle_done = 1'b0;
  endtask

  task automatic load_table(input int n);
    wr(R_TADDR, 32'h0);
    for (int i = 0; i < n; i++) wr(R_TDATA, 32'(tbl[i]));
  endtask

  // Model: after k cycle_done pulses the output is entry k (mod len when looping);
  // a one-shot burst halts on pulse number len and holds the last entry.
  task automatic run_burst(input int len, input bit lp, input int ndone, input int gap_max);
    logic [31:0] r;
    int h0;
    wr(R_STATUS, 32'hE);
    wr(R_LENGTH, 32'(len));
    wr(R_CTRL, lp ? 32'h3 : 32'h1);
    pulse(1'b1);
    check("start_no_halt", 32'(qcw_halt), 32'd0);
    idle(2);
    check("phase_first", 32'(qcw_phase_value), 32'(tbl[0]));
    rd(R_STATUS, r);
    check("busy_running", r, 32'h1);
    h0 = halt_cnt;
    for (int k = 1; k <= ndone; k++) begin
      idle($urandom_range(1, gap_max));
      pulse(1'b0);
      if (!lp && k == len) begin
        check("halt_at_end", 32'(qcw_halt), 32'd1);
        check("phase_hold", 32'(qcw_phase_value), 32'(tbl[len-1]));
      end else begin
        check("halt_none", 32'(qcw_halt), 32'd0);
        check("phase_step", 32'(qcw_phase_value), 32'(tbl[lp ? (k % len) : k]));
      end
    end
    rd(R_CYCLE, r);
    check("cycle_count", r, 32'(ndone));
    rd(R_LOOP, r);
    check("loop_count", r, lp ? 32'(ndone / len) : 32'd0);
    if (lp) begin
      check("loop_no_halt", 32'(halt_cnt - h0), 32'd0);
      wr(R_CTRL, 32'h4);
      check("abort_halt", 32'(halt_at_ack), 32'd1);
      rd(R_STATUS, r);
      check("status_after_abort", r, 32'h0);
    end else begin
      rd(R_STATUS, r);
      check("status_done", r, 32'h2);
    end
  endtask

  initial begin
    logic [31:0] r;
    int cnt;

    // Reset state
    idle(3);
    check("rst_phase", 32'(qcw_phase_value), 32'd0);
    check("rst_halt", 32'(qcw_halt), 32'd0);
    check("rst_ready", 32'(mem_ready_o), 32'd0);
    check("rst_rdata", mem_rdata_o, 32'd0);
    reset = 1'b0;
    idle(1);
    rd(R_STATUS, r); check("rst_status", r, 32'h0);
    rd(R_LENGTH, r); check("rst_length", r, 32'h0);
    rd(R_CTRL, r);   check("rst_ctrl", r, 32'h0);
    idle(1);
    check("rdata_idle_zero", mem_rdata_o, 32'd0);

    // One-shot and looped replay of 10,20,30
    tbl[0] = 8'd10; tbl[1] = 8'd20; tbl[2] = 8'd30;
    load_table(3);
    rd(R_TADDR, r); check("taddr_after_load", r, 32'd3);
    rd(R_TDATA, r); check("tdata_reads_zero", r, 32'd0);
    run_burst(3, 1'b0, 3, 8);
    run_burst(3, 1'b1, 7, 8);

    // Start with LENGTH=0 -> underrun
    wr(R_LENGTH, 32'h0);
    wr(R_CTRL, 32'h1);
    pulse(1'b1);
    check("underrun_halt", 32'(qcw_halt), 32'd1);
    rd(R_STATUS, r); check("underrun_status", r, 32'h4);
    wr(R_STATUS, 32'h4);
    rd(R_STATUS, r); check("underrun_w1c", r, 32'h0);

    // cycle_done while idle, then start with enable=0
    pulse(1'b0);
    check("idle_done_halt", 32'(qcw_halt), 32'd1);
    rd(R_STATUS, r); check("idle_done_underrun", r, 32'h4);
    wr(R_STATUS, 32'hE);
    wr(R_LENGTH, 32'd3);
    wr(R_CTRL, 32'h0);
    pulse(1'b1);
    check("disabled_no_halt", 32'(qcw_halt), 32'd0);
    rd(R_STATUS, r); check("disabled_idle", r, 32'h0);

    // LENGTH clamps to DEPTH
    wr(R_LENGTH, 32'd100);
    rd(R_LENGTH, r); check("length_clamp", r, 32'(DEPTH));

    // Writes during a burst are dropped; held valid gives one ready
    wr(R_LENGTH, 32'd3);
    wr(R_CTRL, 32'h1);
    pulse(1'b1);
    idle(2);
    wr(R_TDATA, 32'h99);
    wr(R_LENGTH, 32'd5);
    rd(R_STATUS, r); check("wr_err_busy", r, 32'h9);
    rd(R_LENGTH, r); check("length_kept", r, 32'd3);
    rd(R_TADDR, r);  check("taddr_kept", r, 32'd3);
    @(posedge clk); #1;
    mem_valid_i = 1'b1; mem_addr_i = BASE + 32'(R_LENGTH); mem_wstrb_i = 4'h0;
    cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (mem_ready_o) cnt++;
    end
    mem_valid_i = 1'b0;
    check("ready_once", 32'(cnt), 32'd1);
    pulse(1'b0);
    check("burst_after_drop", 32'(qcw_phase_value), 32'(tbl[1]));

    // Reset mid-RUN
    idle(2);
    reset = 1'b1;
    idle(1);
    check("midrst_phase", 32'(qcw_phase_value), 32'd0);
    check("midrst_halt", 32'(qcw_halt), 32'd0);
    reset = 1'b0;
    rd(R_STATUS, r); check("midrst_busy", r, 32'h0);
    rd(R_LENGTH, r); check("midrst_length", r, 32'h0);
    wr(R_TADDR, 32'(DEPTH - 1));
    wr(R_TDATA, 32'h11);
    wr(R_TDATA, 32'h22);
    rd(R_TADDR, r); check("taddr_wrap", r, 32'd1);

    // Randomized bursts
    for (int b = 0; b < 14; b++) begin
      int len;
      bit lp;
      len = $urandom_range(1, 6);
      lp  = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) tbl[i] = 8'($urandom);
      load_table(len);
      run_burst(len, lp, lp ? $urandom_range(1, 3 * len + 2) : len, 5);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
